// File: rtl/controle_entrada_saida_if.sv
// Handshake between the I/O sequencer, the core control unit and the board I/O.
// master = control unit / board side, slave = the sequencer.
interface controle_entrada_saida_if #(
    parameter int LARGURA_SW = 16
);
    logic                  congela_in;
    logic                  congela_out;
    logic                  botao;
    logic [LARGURA_SW-1:0] chaves;
    logic [31:0]           dado_out;
    logic                  congela;
    logic [31:0]           dado_in;
    logic                  escreve_in;
    logic [31:0]           display;
    logic                  ocupado_out;

    modport master (
        output congela_in, congela_out, botao, chaves, dado_out,
        input  congela, dado_in, escreve_in, display, ocupado_out
    );

    modport slave (
        input  congela_in, congela_out, botao, chaves, dado_out,
        output congela, dado_in, escreve_in, display, ocupado_out
    );
endinterface

// File: rtl/controle_entrada_saida.sv
// I/O sequencer for the single-cycle MIPS core: stalls for switch input (IN) and display hold (OUT).
// Define ES_CONFIRMA_OUT_EN to end an OUT on a button press instead of after CICLOS_OUT cycles.
module controle_entrada_saida #(
    parameter int LARGURA_SW = 16,
    parameter int CICLOS_OUT = 50_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    controle_entrada_saida_if.slave  bus
);
    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_IN,
        FIM_IN,
        MOSTRA_OUT,
        FIM_OUT
    } estado_t;

    estado_t               r_estado;
    logic                  r_botao_s1, r_botao_s2, r_botao_s3;
    logic                  r_borda;
    logic [LARGURA_SW-1:0] r_chaves_s1, r_chaves_s2;
    logic                  r_congela;
    logic                  r_escreve_in;
    logic                  r_ocupado_out;
    logic [31:0]           r_dado_in;
    logic [31:0]           r_display;
    logic                  w_congela;

`ifndef ES_CONFIRMA_OUT_EN
    localparam int LARGURA_CNT = (CICLOS_OUT > 1) ? $clog2(CICLOS_OUT) : 1;
    logic [LARGURA_CNT-1:0] r_contador;
`endif

    // Button and switches come straight from the board; r_borda is a
    // one-cycle pulse per fresh press, so a button already held never counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_botao_s1  <= 1'b0;
            r_botao_s2  <= 1'b0;
            r_botao_s3  <= 1'b0;
            r_borda     <= 1'b0;
            r_chaves_s1 <= '0;
            r_chaves_s2 <= '0;
        end else begin
            r_botao_s1  <= bus.botao;
            r_botao_s2  <= r_botao_s1;
            r_botao_s3  <= r_botao_s2;
            r_borda     <= r_botao_s2 & ~r_botao_s3;
            r_chaves_s1 <= bus.chaves;
            r_chaves_s2 <= r_chaves_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado      <= OCIOSO;
            r_congela     <= 1'b0;
            r_escreve_in  <= 1'b0;
            r_ocupado_out <= 1'b0;
            r_dado_in     <= '0;
            r_display     <= '0;
`ifndef ES_CONFIRMA_OUT_EN
            r_contador    <= '0;
`endif
        end else begin
            r_escreve_in <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (bus.congela_in) begin
                        r_estado  <= ESPERA_IN;
                        r_congela <= 1'b1;
                    end else if (bus.congela_out) begin
                        r_estado      <= MOSTRA_OUT;
                        r_congela     <= 1'b1;
                        r_ocupado_out <= 1'b1;
                        r_display     <= bus.dado_out;
`ifndef ES_CONFIRMA_OUT_EN
                        r_contador    <= LARGURA_CNT'(CICLOS_OUT - 1);
`endif
                    end
                end
                ESPERA_IN: begin
                    if (r_borda) begin
                        r_estado     <= FIM_IN;
                        r_congela    <= 1'b0;
                        r_escreve_in <= 1'b1;
                        r_dado_in    <= 32'(r_chaves_s2);
                    end
                end
                FIM_IN: r_estado <= OCIOSO;
                MOSTRA_OUT: begin
`ifdef ES_CONFIRMA_OUT_EN
                    if (r_borda) begin
                        r_estado      <= FIM_OUT;
                        r_congela     <= 1'b0;
                        r_ocupado_out <= 1'b0;
                    end
`else
                    if (r_contador == '0) begin
                        r_estado      <= FIM_OUT;
                        r_congela     <= 1'b0;
                        r_ocupado_out <= 1'b0;
                    end else begin
                        r_contador <= r_contador - 1'b1;
                    end
`endif
                end
                FIM_OUT: r_estado <= OCIOSO;
                default: begin
                    r_estado      <= OCIOSO;
                    r_congela     <= 1'b0;
                    r_ocupado_out <= 1'b0;
                end
            endcase
        end
    end

    // In OCIOSO the stall must act in the same cycle the instruction appears,
    // otherwise it would retire before the sequencer reacts.
    always_comb begin
        w_congela = r_congela;
        if (r_estado == OCIOSO)
            w_congela = bus.congela_in | bus.congela_out;
    end

    assign bus.congela     = w_congela;
    assign bus.dado_in     = r_dado_in;
    assign bus.escreve_in  = r_escreve_in;
    assign bus.display     = r_display;
    assign bus.ocupado_out = r_ocupado_out;
endmodule
